// File: rtl/hdmi_timing_pkg.sv
// Shared types and defaults for the HDMI video timing generator.
// Timing fields are packed MSB-first in the order h_active .. v_bp.
package hdmi_timing_pkg;

    localparam int TIMING_FIELD_W = 12;

    typedef struct packed {
        logic [TIMING_FIELD_W-1:0] h_active;
        logic [TIMING_FIELD_W-1:0] h_fp;
        logic [TIMING_FIELD_W-1:0] h_sync;
        logic [TIMING_FIELD_W-1:0] h_bp;
        logic [TIMING_FIELD_W-1:0] v_active;
        logic [TIMING_FIELD_W-1:0] v_fp;
        logic [TIMING_FIELD_W-1:0] v_sync;
        logic [TIMING_FIELD_W-1:0] v_bp;
    } timing_t;

    // Bundle carried through the output delay line, in output-level form.
    typedef struct packed {
        logic de;
        logic vsync;
        logic hsync;
    } vid_t;

    localparam timing_t DEFAULT_TIMING = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd11, v_sync: 12'd2,  v_bp: 12'd31
    };

    function automatic logic [TIMING_FIELD_W-1:0] h_total(input timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic logic [TIMING_FIELD_W-1:0] v_total(input timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_sync_delay_line.sv
// Fixed-depth shift register aligning de/vsync/hsync with frame-buffer data.
// Resets to the inactive video levels; depth 0 degenerates to a wire.
module sync_delay_line #(
    parameter int         DEPTH   = 2,
    parameter logic [2:0] RST_VAL = 3'b011
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_shift
            logic [2:0] sr_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr_q[i] <= RST_VAL;
                    end
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/hdmi_timing_gen.sv
// Run-time reloadable video timing generator: syncs, DE, pixel coordinates
// and a down-scaled frame-buffer read address for the ADV7511 output path.
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int      CNT_W          = TIMING_FIELD_W,
    parameter int      FRAME_X_SCALE  = 0,
    parameter int      FRAME_Y_SCALE  = 0,
    parameter int      FB_ADDR_W      = 19,
    parameter int      PIPE_DELAY     = 2,
    parameter logic    HSYNC_POL      = 1'b0,
    parameter logic    VSYNC_POL      = 1'b0,
    parameter timing_t DEFAULT_TIMING = hdmi_timing_pkg::DEFAULT_TIMING
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    // cfg handshake: a transfer happens on any cycle where cfg_valid_i and
    // cfg_ready_o are both high; cfg_i is sampled only then. Ready is high
    // while disabled, otherwise only on the last cycle of a frame.
    input  logic [8*CNT_W-1:0]   cfg_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic                 fb_rd_o,
    output logic [FB_ADDR_W-1:0] fb_addr_o,
    output logic [CNT_W-1:0]     x_o,
    output logic [CNT_W-1:0]     y_o,
    output logic                 frame_start_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o
);

    localparam vid_t VID_IDLE = '{de: 1'b0, vsync: ~VSYNC_POL, hsync: ~HSYNC_POL};
    localparam logic [CNT_W-1:0] X_SUB_MAX = CNT_W'((1 << FRAME_X_SCALE) - 1);
    localparam logic [CNT_W-1:0] Y_MASK    = CNT_W'((1 << FRAME_Y_SCALE) - 1);

    timing_t              tim_q, tim_d;
    logic [CNT_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]     h_tot, v_tot, hs_start, hs_end, vs_start, vs_end;
    logic                 h_last, v_last, cfg_accept;
    logic                 de_c, hsync_c, vsync_c, fs_c, line_end;

    logic [FB_ADDR_W-1:0] line_base_q, line_base_d, addr_cnt_q, addr_cnt_d;
    logic [FB_ADDR_W-1:0] fb_line_w;
    logic [CNT_W-1:0]     x_sub_q, x_sub_d;

    logic                 fb_rd_q, fb_rd_d, fs_q, fs_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [CNT_W-1:0]     x_q, x_d, y_q, y_d;
    vid_t                 vid_q, vid_d, vid_dly;

    // ---------------- counter stage ----------------
    assign h_tot      = h_total(tim_q);
    assign v_tot      = v_total(tim_q);
    assign h_last     = (h_cnt_q == h_tot - CNT_W'(1));
    assign v_last     = (v_cnt_q == v_tot - CNT_W'(1));
    assign cfg_ready_o = ~en_i | (h_last & v_last);
    assign cfg_accept = cfg_valid_i & cfg_ready_o;

    always_comb begin
        tim_d   = tim_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (cfg_accept) begin
            tim_d = timing_t'(cfg_i);
        end
        if (!en_i || cfg_accept) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end
    end

    assign hs_start = tim_q.h_active + tim_q.h_fp;
    assign hs_end   = hs_start + tim_q.h_sync;
    assign vs_start = tim_q.v_active + tim_q.v_fp;
    assign vs_end   = vs_start + tim_q.v_sync;

    assign de_c     = en_i & (h_cnt_q < tim_q.h_active) & (v_cnt_q < tim_q.v_active);
    assign hsync_c  = en_i & (h_cnt_q >= hs_start) & (h_cnt_q < hs_end);
    assign vsync_c  = en_i & (v_cnt_q >= vs_start) & (v_cnt_q < vs_end);
    assign fs_c     = en_i & (h_cnt_q == '0) & (v_cnt_q == '0);
    assign line_end = de_c & (h_cnt_q == tim_q.h_active - CNT_W'(1));

    // ---------------- incremental frame-buffer address ----------------
    // addr_cnt_q is the address of the pixel currently in the counter stage;
    // lines sharing a scaled row rewind to line_base_q, the last one advances it.
    assign fb_line_w = FB_ADDR_W'(tim_q.h_active >> FRAME_X_SCALE);

    always_comb begin
        line_base_d = line_base_q;
        addr_cnt_d  = addr_cnt_q;
        x_sub_d     = x_sub_q;
        if (line_end) begin
            x_sub_d = '0;
            if ((v_cnt_q & Y_MASK) == Y_MASK) begin
                line_base_d = line_base_q + fb_line_w;
                addr_cnt_d  = line_base_q + fb_line_w;
            end else begin
                addr_cnt_d  = line_base_q;
            end
        end else if (de_c) begin
            if (x_sub_q == X_SUB_MAX) begin
                x_sub_d    = '0;
                addr_cnt_d = addr_cnt_q + FB_ADDR_W'(1);
            end else begin
                x_sub_d    = x_sub_q + CNT_W'(1);
            end
        end
        if (!en_i || (h_cnt_d == '0 && v_cnt_d == '0)) begin
            line_base_d = '0;
            addr_cnt_d  = '0;
            x_sub_d     = '0;
        end
    end

    // ---------------- registered output stage ----------------
    always_comb begin
        fb_rd_d   = de_c;
        fb_addr_d = addr_cnt_q;
        fs_d      = fs_c;
        x_d       = x_q;
        y_d       = y_q;
        if (de_c) begin
            x_d = h_cnt_q;
            y_d = v_cnt_q;
        end
        vid_d.de    = de_c;
        vid_d.hsync = hsync_c ? HSYNC_POL : ~HSYNC_POL;
        vid_d.vsync = vsync_c ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tim_q       <= DEFAULT_TIMING;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_base_q <= '0;
            addr_cnt_q  <= '0;
            x_sub_q     <= '0;
            fb_rd_q     <= 1'b0;
            fb_addr_q   <= '0;
            fs_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            vid_q       <= VID_IDLE;
        end else begin
            tim_q       <= tim_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_base_q <= line_base_d;
            addr_cnt_q  <= addr_cnt_d;
            x_sub_q     <= x_sub_d;
            fb_rd_q     <= fb_rd_d;
            fb_addr_q   <= fb_addr_d;
            fs_q        <= fs_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vid_q       <= vid_d;
        end
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (VID_IDLE)
    ) u_sync_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (vid_q),
        .q_o   (vid_dly)
    );

    assign fb_rd_o       = fb_rd_q;
    assign fb_addr_o     = fb_addr_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = fs_q;
    assign de_o          = vid_dly.de;
    assign hsync_o       = vid_dly.hsync;
    assign vsync_o       = vid_dly.vsync;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Randomized bench for hdmi_timing_gen: a default-parameter instance and a
// scaled, active-high, zero-delay instance share stimulus and one frame model.
module tb_hdmi_timing_gen;
    import hdmi_timing_pkg::*;

    logic        clk, rst, en, cfg_valid;
    timing_t     cfg;

    logic        rdy0, fb_rd0, fs0, hs0, vs0, de0;
    logic [18:0] fb_addr0;
    logic [11:0] x0, y0;
    logic        rdy1, fb_rd1, fs1, hs1, vs1, de1;
    logic [18:0] fb_addr1;
    logic [11:0] x1, y1;

    int n_checks = 0;
    int n_fail   = 0;
    bit obs_acc;

    typedef struct {
        bit de; bit hs; bit vs; bit fs;
        int x; int y; int a0; int a1;
    } stage_t;

    // frame model: position of the counter stage in the current cycle
    timing_t m_tim;
    int      mh, mv, xh, yh;
    stage_t  hist[$];

    hdmi_timing_gen dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_i(cfg), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(rdy0), .fb_rd_o(fb_rd0), .fb_addr_o(fb_addr0), .x_o(x0), .y_o(y0),
        .frame_start_o(fs0), .hsync_o(hs0), .vsync_o(vs0), .de_o(de0)
    );

    hdmi_timing_gen #(
        .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1), .PIPE_DELAY(0),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_s (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_i(cfg), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(rdy1), .fb_rd_o(fb_rd1), .fb_addr_o(fb_addr1), .x_o(x1), .y_o(y1),
        .frame_start_o(fs1), .hsync_o(hs1), .vsync_o(vs1), .de_o(de1)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic timing_t rand_cfg();
        timing_t t;
        t.h_active = TIMING_FIELD_W'($urandom_range(4, 12));
        t.h_fp     = TIMING_FIELD_W'($urandom_range(1, 3));
        t.h_sync   = TIMING_FIELD_W'($urandom_range(1, 3));
        t.h_bp     = TIMING_FIELD_W'($urandom_range(1, 3));
        t.v_active = TIMING_FIELD_W'($urandom_range(2, 6));
        t.v_fp     = TIMING_FIELD_W'($urandom_range(1, 2));
        t.v_sync   = TIMING_FIELD_W'($urandom_range(1, 2));
        t.v_bp     = TIMING_FIELD_W'($urandom_range(1, 2));
        return t;
    endfunction

    function automatic int tot_h(input timing_t t);
        return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    endfunction

    function automatic int tot_v(input timing_t t);
        return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    endfunction

    task automatic model_reset();
        stage_t idle;
        idle = '{de: 0, hs: 0, vs: 0, fs: 0, x: 0, y: 0, a0: 0, a1: 0};
        m_tim = DEFAULT_TIMING;
        mh = 0; mv = 0; xh = 0; yh = 0;
        hist.delete();
        repeat (4) hist.push_back(idle);
    endtask

    // Expected outputs come from the stage history: registered outputs show
    // the previous cycle's stage, delayed outputs show it PIPE_DELAY later.
    task automatic check_outputs();
        stage_t r, d2;
        r  = hist[hist.size()-1];
        d2 = hist[hist.size()-3];
        check_eq("fb_rd", 32'(fb_rd0), 32'(r.de));
        if (r.de) check_eq("fb_addr", 32'(fb_addr0), 32'(r.a0));
        check_eq("x", 32'(x0), 32'(r.x));
        check_eq("y", 32'(y0), 32'(r.y));
        check_eq("frame_start", 32'(fs0), 32'(r.fs));
        check_eq("de", 32'(de0), 32'(d2.de));
        check_eq("hsync", 32'(hs0), 32'(!d2.hs));
        check_eq("vsync", 32'(vs0), 32'(!d2.vs));
        check_eq("fb_rd_s", 32'(fb_rd1), 32'(r.de));
        if (r.de) check_eq("fb_addr_s", 32'(fb_addr1), 32'(r.a1));
        check_eq("x_s", 32'(x1), 32'(r.x));
        check_eq("y_s", 32'(y1), 32'(r.y));
        check_eq("frame_start_s", 32'(fs1), 32'(r.fs));
        check_eq("de_s", 32'(de1), 32'(r.de));
        check_eq("hsync_s", 32'(hs1), 32'(r.hs));
        check_eq("vsync_s", 32'(vs1), 32'(r.vs));
    endtask

    task automatic model_step();
        int ha, hfp, hsw, va, vfp, vsw, ht, vt;
        bit rdy, act;
        stage_t s;
        ha  = int'(m_tim.h_active); hfp = int'(m_tim.h_fp); hsw = int'(m_tim.h_sync);
        va  = int'(m_tim.v_active); vfp = int'(m_tim.v_fp); vsw = int'(m_tim.v_sync);
        ht  = tot_h(m_tim);
        vt  = tot_v(m_tim);
        rdy = !en || (mh == ht - 1 && mv == vt - 1);
        check_eq("cfg_ready", 32'(rdy0), 32'(rdy));
        check_eq("cfg_ready_s", 32'(rdy1), 32'(rdy));
        obs_acc = cfg_valid && rdy0;
        act = en && mh < ha && mv < va;
        if (act) begin
            xh = mh;
            yh = mv;
        end
        s.de = act;
        s.hs = en && mh >= ha + hfp && mh < ha + hfp + hsw;
        s.vs = en && mv >= va + vfp && mv < va + vfp + vsw;
        s.fs = en && mh == 0 && mv == 0;
        s.x  = xh;
        s.y  = yh;
        s.a0 = mv * ha + mh;
        s.a1 = (mv / 2) * (ha / 2) + mh / 2;
        hist.push_back(s);
        if (hist.size() > 8) hist.delete(0);
        if (cfg_valid && rdy) begin
            m_tim = cfg;
            mh = 0; mv = 0;
        end else if (!en) begin
            mh = 0; mv = 0;
        end else begin
            mh++;
            if (mh == ht) begin
                mh = 0;
                mv++;
                if (mv == vt) mv = 0;
            end
        end
    endtask

    // driver: one pixel-clock cycle of stimulus plus its checks
    task automatic cycle(input bit e, input bit v, input timing_t c);
        @(negedge clk);
        check_outputs();
        en = e;
        cfg_valid = v;
        cfg = c;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        en = 1'b0;
        cfg_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        timing_t small_cfg, nc;
        int cnt_a, cnt_b, pre, wait_n, expw, ht, vt;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg = DEFAULT_TIMING;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_fb_rd", 32'(fb_rd0), 32'd0);
        check_eq("rst_fb_addr", 32'(fb_addr0), 32'd0);
        check_eq("rst_x", 32'(x0), 32'd0);
        check_eq("rst_y", 32'(y0), 32'd0);
        check_eq("rst_frame_start", 32'(fs0), 32'd0);
        check_eq("rst_de", 32'(de0), 32'd0);
        check_eq("rst_hsync", 32'(hs0), 32'd1);
        check_eq("rst_vsync", 32'(vs0), 32'd1);
        check_eq("rst_cfg_ready", 32'(rdy0), 32'd1);
        check_eq("rst_hsync_s", 32'(hs1), 32'd0);
        check_eq("rst_vsync_s", 32'(vs1), 32'd0);
        rst = 1'b0;

        // default 640x480 timing over two lines
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 1700; i++) begin
            cycle(1'b1, 1'b0, rand_cfg());
            if (i >= 10 && i < 810) begin
                cnt_a += int'(!hs0);
                cnt_b += int'(de0);
            end
        end
        check_eq("hsync_low_per_line", 32'(cnt_a), 32'd96);
        check_eq("de_per_line", 32'(cnt_b), 32'd640);

        // small mode loaded while disabled
        small_cfg = '{12'd8, 12'd2, 12'd3, 12'd3, 12'd4, 12'd1, 12'd1, 12'd2};
        cycle(1'b0, 1'b0, small_cfg);
        cycle(1'b0, 1'b1, small_cfg);
        check_eq("small_accept", 32'(obs_acc), 32'd1);
        cycle(1'b0, 1'b0, small_cfg);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, 1'b0, rand_cfg());
            if (i >= 1 && i < 385) begin
                cnt_a += int'(fs0);
                cnt_b += int'(de0);
            end
        end
        check_eq("small_frame_starts", 32'(cnt_a), 32'd3);
        check_eq("small_de_count", 32'(cnt_b), 32'd96);

        // reload requested mid-frame: held until the frame's last cycle
        for (int it = 0; it < 4; it++) begin
            nc  = rand_cfg();
            pre = $urandom_range(3, 60);
            repeat (pre) cycle(1'b1, 1'b0, rand_cfg());
            ht   = tot_h(m_tim);
            vt   = tot_v(m_tim);
            expw = (vt - 1 - mv) * ht + (ht - 1 - mh);
            wait_n = 0;
            cycle(1'b1, 1'b1, nc);
            while (!obs_acc && wait_n < 5000) begin
                wait_n++;
                cycle(1'b1, 1'b1, nc);
            end
            check_eq("accept_wait", 32'(wait_n), 32'(expw));
            repeat (300) cycle(1'b1, 1'b0, rand_cfg());
        end

        // enable dropped mid-line for five cycles
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(5, 40)) cycle(1'b1, 1'b0, rand_cfg());
            repeat (5) cycle(1'b0, 1'b0, rand_cfg());
            repeat ($urandom_range(20, 80)) cycle(1'b1, 1'b0, rand_cfg());
        end

        // random enable and reload traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0, rand_cfg());
        end

        // asynchronous reset mid-frame
        repeat (37) cycle(1'b1, 1'b0, rand_cfg());
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_hsync_s", 32'(hs1), 32'd0);
        check_eq("async_rst_fb_addr", 32'(fb_addr0), 32'd0);
        check_eq("async_rst_fb_addr_s", 32'(fb_addr1), 32'd0);
        check_eq("async_rst_fb_rd", 32'(fb_rd0), 32'd0);
        check_eq("async_rst_de_s", 32'(de1), 32'd0);
        do_reset();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 1700; i++) begin
            cycle(1'b1, 1'b0, rand_cfg());
            if (i >= 10 && i < 810) begin
                cnt_a += int'(hs1);
                cnt_b += int'(de0);
            end
        end
        check_eq("post_rst_hsync_per_line", 32'(cnt_a), 32'd96);
        check_eq("post_rst_de_per_line", 32'(cnt_b), 32'd640);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_gen.md
# hdmi_timing_gen

Parametrised video timing generator for the HDMI (ADV7511) output path, replacing the fixed-mode timing logic inside the HDMI controller. It produces HSYNC/VSYNC/DE with configurable polarity, pixel coordinates, and a down-scaled frame-buffer read address, with a fixed pipeline delay so that syncs line up with frame-buffer data. The video mode can be reloaded at run time through a handshake, and the new mode takes effect only at a frame boundary. It sits between the frame buffer and the HDMI data/sync registers in the pixel-clock domain.

## Interface
- CNT_W, 12, width of each timing field and of the h/v counters
- FRAME_X_SCALE, 0, horizontal down-scale; frame-buffer X = active pixels >> FRAME_X_SCALE
- FRAME_Y_SCALE, 0, vertical down-scale; frame-buffer Y = active lines >> FRAME_Y_SCALE
- FB_ADDR_W, 19, frame-buffer address width (19 bits cover 640*480)
- PIPE_DELAY, 2, cycles from fb_rd_o to valid frame-buffer data; 0 is legal
- HSYNC_POL, 0, 1 = active-high hsync
- VSYNC_POL, 0, 1 = active-high vsync
- DEFAULT_TIMING, 640/16/96/48 x 480/11/2/31, reset value of the active timing
- clk_i  in  1  pixel clock; the block has this one clock only
- rst_i  in  1  reset, asynchronous and active-high
- en_i  in  1  run enable
- cfg_i  in  8*CNT_W  timing_t: h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp
- cfg_valid_i  in  1  a new timing is offered
- cfg_ready_o  out  1  the new timing can be accepted this cycle
- fb_rd_o  out  1  frame-buffer read strobe
- fb_addr_o  out  FB_ADDR_W  frame-buffer read address
- x_o, y_o  out  CNT_W each  active pixel coordinate, unscaled
- frame_start_o  out  1  one-cycle pulse at h=0, v=0
- hsync_o, vsync_o, de_o  out  1 each  video outputs, delayed by PIPE_DELAY

## Operation
- Counters run in the order active, front porch, sync, back porch.
  - h_cnt counts 0..h_total-1, where h_total is the sum of the four h fields.
  - v_cnt counts 0..v_total-1 and advances when h_cnt wraps.
- active = (h_cnt < h_active) && (v_cnt < v_active).
- hsync is asserted while h_cnt is in [h_active+h_fp, h_active+h_fp+h_sync). vsync uses the same rule on v_cnt.
- Frame-buffer address is generated incrementally, with no multiplier:
  - line_base and fb_addr are cleared at frame start.
  - fb_addr increments after every 2^FRAME_X_SCALE active pixels.
  - At the end of an active line:
    - if the low FRAME_Y_SCALE bits of v_cnt are all ones, line_base += h_active>>FRAME_X_SCALE;
    - otherwise fb_addr rewinds to line_base.
- All arithmetic is unsigned CNT_W. The sum of the four fields in each direction must fit in CNT_W; this is not checked.
- Config handshake:
  - cfg_ready_o = ~en_i, or (h_cnt==h_total-1 && v_cnt==v_total-1).
  - cfg_valid_i && cfg_ready_o loads the shadow timing. The next cycle starts a frame at 0,0 with the new timing.
  - cfg_i is ignored when not accepted.
- en_i low:
  - counters, line_base and fb_addr are forced to 0;
  - fb_rd_o=0, de_o=0, syncs at their inactive level;
  - the delay line keeps shifting inactive values.
- en_i rising: the first enabled cycle is h=0, v=0, and frame_start_o pulses in the registered output stage.
- Reset mid-frame: every register returns immediately to its reset value. The timing returns to DEFAULT_TIMING.

## Timing
- Counter stage is cycle c.
- fb_rd_o, fb_addr_o, x_o, y_o and frame_start_o are registered at c+1.
- de_o, hsync_o and vsync_o appear at c+1+PIPE_DELAY, through the delay line.
- Reset values:
  - fb_rd_o=0, fb_addr_o=0, x_o=0, y_o=0, frame_start_o=0, de_o=0, cfg_ready_o=1;
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
- x_o and y_o hold their last values outside the active region.
- With cfg_valid_i held high during a frame, acceptance happens on exactly one cycle: the last cycle of that frame.

## Structure
- Package hdmi_timing_pkg holds:
  - timing_t (packed struct, 8 fields of CNT_W);
  - DEFAULT_TIMING;
  - helper functions h_total() and v_total().
- Sub-module sync_delay_line: a PIPE_DELAY-deep, 3-bit shift register that resets to the inactive levels. PIPE_DELAY=0 makes it a wire.

## Test plan
- Reset with defaults, en_i=1 -> hsync period 800 cycles, low for 96 cycles; vsync period 419200 cycles; 640 de cycles per line; fb_addr_o reaches 307199 on the last active pixel.
- Load cfg 8/2/3/3 x 4/1/1/2 while en_i=0 -> line = 16 cycles, frame = 128 cycles; de_o lags fb_rd_o by exactly 2 cycles.
- FRAME_X_SCALE=1, FRAME_Y_SCALE=1 with the small cfg -> addresses 0,0,1,1,2,2,3,3 on lines 0 and 1, then 4..7 pairs on lines 2 and 3.
- cfg_valid_i raised mid-frame -> cfg_ready_o low until the last cycle of the frame; the next frame uses the new totals; frame_start_o pulses once.
- en_i dropped mid-line and raised 5 cycles later -> outputs inactive within PIPE_DELAY+1 cycles; restart at 0,0 with a frame_start_o pulse.
- rst_i asserted mid-frame with HSYNC_POL=1 -> hsync_o=0 and fb_addr_o=0 immediately (asynchronous); after release the timing is back to DEFAULT_TIMING.
